// File: rtl/pid_pwm_pkg.sv
// Shared types and helpers for the PID-to-PWM output stage.
`timescale 1ns/1ps
package pid_pwm_pkg;

    localparam int U_W = 6;

    typedef struct packed {
        logic           dir;
        logic [U_W-1:0] mag;
    } cmd_t;

    // |v| of a two's-complement word, clipped to limit (-32 gives 32 before clipping)
    function automatic logic [U_W-1:0] sat_abs(input logic [U_W-1:0] v, input logic [U_W:0] limit);
        logic [U_W:0] a;
        if (v[U_W-1]) begin
            a = {1'b0, ~v} + {{U_W{1'b0}}, 1'b1};
        end else begin
            a = {1'b0, v};
        end
        if (a > limit) begin
            return limit[U_W-1:0];
        end else begin
            return a[U_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pid_pwm_prescaler.sv
// Clock prescaler: pre counts 0..PRESCALE-1 while enabled; its wrap strobes cnt_en.
`timescale 1ns/1ps
module pid_pwm_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic cnt_en
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_r;
    logic          wrap_s;

    assign wrap_s = (pre_r == PW'(PRESCALE - 1));
    assign cnt_en = ena & wrap_s;

    // Prescale counter, frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PW{1'b0}};
        end else if (ena) begin
            if (wrap_s) begin
                pre_r <= {PW{1'b0}};
            end else begin
                pre_r <= pre_r + PW'(1);
            end
        end else begin
            pre_r <= pre_r;
        end
    end

endmodule

// File: rtl/pid_pwm_driver.sv
// Sign-magnitude PWM drive with period-boundary double buffering of the control word.
// Optional H-bridge dead period on reversal: define PID_PWM_DEADTIME_EN.
`timescale 1ns/1ps
module pid_pwm_driver
    import pid_pwm_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [U_W-1:0] u,
    input  logic           u_valid,
    output logic           pwm_out,
    output logic           dir_out,
    output logic           period_tick,
    output logic           overrun
);

    localparam int PER     = (1 << CNT_W) - 1;
    localparam int CW      = (CNT_W > U_W) ? CNT_W : U_W;
    localparam int MAG_LIM = (PER < (1 << (U_W - 1))) ? PER : (1 << (U_W - 1));
    localparam logic [U_W:0] MAG_LIM_V = MAG_LIM[U_W:0];

    logic             cnt_en_s;
    logic             u_vld_s;
    logic             bnd_s;
    logic             pwm_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    cmd_t             pend_r, act_r, act_nxt_s, new_cmd_s;
    logic             pwm_r, tick_r, ovr_r, got_r;
`ifdef PID_PWM_DEADTIME_EN
    logic             dead_r, dead_nxt_s;
`endif

    pid_pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .cnt_en (cnt_en_s)
    );

    // Next-state of counter, command capture and active register
    always_comb begin
        u_vld_s       = u_valid & ena;
        bnd_s         = cnt_en_s & (cnt_r == CNT_W'(PER - 1));
        new_cmd_s.mag = sat_abs(u, MAG_LIM_V);
        if (u == {U_W{1'b0}}) begin
            new_cmd_s.dir = pend_r.dir;
        end else begin
            new_cmd_s.dir = u[U_W-1];
        end
        if (!cnt_en_s) begin
            cnt_nxt_s = cnt_r;
        end else if (bnd_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
        act_nxt_s = act_r;
`ifdef PID_PWM_DEADTIME_EN
        dead_nxt_s = dead_r;
        if (bnd_s) begin
            // Reversal with drive: hold the old direction at zero duty for one period
            if (!dead_r && (pend_r.dir != act_r.dir) && (pend_r.mag != {U_W{1'b0}})) begin
                act_nxt_s.dir = act_r.dir;
                act_nxt_s.mag = {U_W{1'b0}};
                dead_nxt_s    = 1'b1;
            end else begin
                act_nxt_s  = pend_r;
                dead_nxt_s = 1'b0;
            end
        end else begin
            act_nxt_s = act_r;
        end
`else
        if (bnd_s) begin
            act_nxt_s = pend_r;
        end else begin
            act_nxt_s = act_r;
        end
`endif
        pwm_nxt_s = ena & (CW'(cnt_nxt_s) < CW'(act_nxt_s.mag));
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            pend_r <= '{dir: 1'b0, mag: {U_W{1'b0}}};
            act_r  <= '{dir: 1'b0, mag: {U_W{1'b0}}};
            pwm_r  <= 1'b0;
            tick_r <= 1'b0;
            ovr_r  <= 1'b0;
            got_r  <= 1'b0;
`ifdef PID_PWM_DEADTIME_EN
            dead_r <= 1'b0;
`endif
        end else begin
            cnt_r  <= cnt_nxt_s;
            act_r  <= act_nxt_s;
            pwm_r  <= pwm_nxt_s;
            tick_r <= bnd_s;
`ifdef PID_PWM_DEADTIME_EN
            dead_r <= dead_nxt_s;
`endif
            if (u_vld_s) begin
                pend_r <= new_cmd_s;
            end else begin
                pend_r <= pend_r;
            end
            // A strobe coinciding with the boundary edge belongs to the new period
            if (bnd_s) begin
                got_r <= u_vld_s;
            end else if (u_vld_s) begin
                got_r <= 1'b1;
            end else begin
                got_r <= got_r;
            end
            ovr_r <= ovr_r | (u_vld_s & got_r & ~bnd_s);
        end
    end

    assign pwm_out     = pwm_r;
    assign dir_out     = act_r.dir;
    assign period_tick = tick_r;
    assign overrun     = ovr_r;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Directed self-checking bench for pid_pwm_driver (PRESCALE=4 and PRESCALE=1 instances).
`timescale 1ns/1ps
module tb_pid_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] u;
    logic       u_valid;
    logic       pwm4, dir4, tick4, ovr4;
    logic       pwm1, dir1, tick1, ovr1;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pid_pwm_driver dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .u(u), .u_valid(u_valid),
        .pwm_out(pwm4), .dir_out(dir4), .period_tick(tick4), .overrun(ovr4)
    );

    pid_pwm_driver #(.CNT_W(5), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .u(u), .u_valid(u_valid),
        .pwm_out(pwm1), .dir_out(dir1), .period_tick(tick1), .overrun(ovr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next period_tick of the PRESCALE=1 instance, bounded
    task automatic wait_tick1(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick1 !== 1'b1 && n < 64);
        check(tag, {31'd0, tick1}, 32'd1);
    endtask

    // Starting in a boundary cycle: check one full 31-cycle period of the PRESCALE=1 instance
    task automatic check_period(input string tag, input int duty, input logic dir);
        for (int k = 0; k < 31; k++) begin
            check(tag, {29'd0, tick1, pwm1, dir1}, {29'd0, (k == 0), (k < duty), dir});
            step();
        end
    endtask

    task automatic apply(input logic [5:0] val);
        u       = val;
        u_valid = 1'b1;
        step();
        u_valid = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        u       = 6'd0;
        u_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle after reset: outputs low, ticks at 124/248 (PRESCALE=4) and every 31 (PRESCALE=1)
        for (int c = 0; c < 300; c++) begin
            check("idle", {26'd0, tick4, pwm4, dir4, tick1, pwm1, dir1},
                  {26'd0, (c == 124 || c == 248), 1'b0, 1'b0, (c > 0 && c % 31 == 0), 1'b0, 1'b0});
            step();
        end
        check("ovr_idle", {30'd0, ovr4, ovr1}, 32'd0);

        // +10: 10 high, 21 low, dir 0
        wait_tick1("sync_a");
        apply(6'd10);
        wait_tick1("tick_p10");
        check_period("duty10", 10, 1'b0);

        // -32 saturates to 31: constantly high, dir 1
        apply(6'b100000);
        wait_tick1("tick_m32");
        check_period("duty31", 31, 1'b1);
        check("duty31_hold", {31'd0, pwm1}, 32'd1);

        // +5 then +20 in one period: overrun, last write wins
        check("ovr_before", {31'd0, ovr1}, 32'd0);
        apply(6'd5);
        check("ovr_single", {31'd0, ovr1}, 32'd0);
        step();
        step();
        apply(6'd20);
        check("ovr_set", {31'd0, ovr1}, 32'd1);
        wait_tick1("tick_p20");
        check_period("duty20", 20, 1'b0);

        // Reversal to -12
        apply(6'b110100);
        wait_tick1("tick_m12");
`ifdef PID_PWM_DEADTIME_EN
        check_period("dead", 0, 1'b0);
`endif
        check_period("duty12neg", 12, 1'b1);

        // u = 0 keeps the previous sign
        apply(6'd0);
        wait_tick1("tick_zero");
        check_period("zero_keep_dir", 0, 1'b1);

        // -20, then disable at cnt=7 for 50 cycles
        apply(6'b101100);
        wait_tick1("tick_m20");
        repeat (7) step();
        check("pre_freeze", {30'd0, pwm1, dir1}, 32'd3);
        ena = 1'b0;
        step();
        for (int i = 0; i < 50; i++) begin
            check("frozen", {29'd0, tick1, pwm1, dir1}, 32'd1);
            if (i == 20) begin
                u       = 6'd3;
                u_valid = 1'b1;
            end else begin
                u_valid = 1'b0;
            end
            step();
        end
        u_valid = 1'b0;
        ena     = 1'b1;
        step();
        for (int j = 8; j < 31; j++) begin
            check("resume", {29'd0, tick1, pwm1, dir1}, {29'd0, 1'b0, (j < 20), 1'b1});
            step();
        end
        check("resume_bnd", {29'd0, tick1, pwm1, dir1}, 32'd7);

        // Asynchronous reset mid-period
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst1", {28'd0, pwm1, dir1, tick1, ovr1}, 32'd0);
        check("async_rst4", {28'd0, pwm4, dir4, tick4, ovr4}, 32'd0);
        step();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
